// File: rtl/uart_pkg.sv
// Shared definitions for the second-generation UART receiver: FSM states,
// parity-mode encodings, the baud-rate table and the 16x divisor function.
// Optional build macro UART_RX_MAJORITY_EN is consumed by uart_rx_gen2.
package uart_pkg;

    typedef enum logic [2:0] {
        StOff,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [1:0] ParNone    = 2'b00;
    localparam logic [1:0] ParEven    = 2'b01;
    localparam logic [1:0] ParOdd     = 2'b10;
    localparam logic [1:0] ParNoneAlt = 2'b11;

    localparam int unsigned BaudTable [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

    // Rounded clk cycles per 16x tick; never returns 0.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz, input logic [2:0] sel);
        longint unsigned baud16;
        longint unsigned div;
        baud16 = 64'(BaudTable[sel]) * 64'd16;
        div    = (64'(clk_hz) + baud16 / 64'd2) / baud16;
        if (div == 64'd0) begin
            div = 64'd1;
        end
        return 32'(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator. Emits a one-cycle pulse every
// baud_divisor(CLK_HZ, baud_select) clocks; restarts on a select change.
// Optional build macro UART_RX_MAJORITY_EN has no effect here.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       tick
);

    // Slowest rate sets the counter width.
    localparam int unsigned MaxDiv = baud_divisor(CLK_HZ, 3'd0);
    localparam int unsigned CntW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;

    logic [CntW-1:0] term_tbl [8];
    logic [CntW-1:0] cnt_q;
    logic [2:0]      sel_q;
    logic            tick_q;

    for (genvar g = 0; g < 8; g++) begin : g_term
        assign term_tbl[g] = CntW'(baud_divisor(CLK_HZ, 3'(g)) - 32'd1);
    end

    // Free-running divider, restarted on reset or a new rate selection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else if (baud_select != sel_q) begin
            sel_q  <= baud_select;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == term_tbl[sel_q]) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CntW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_gen2.sv
// 16x-oversampled UART receiver with runtime parity / stop-bit setup,
// parity, framing and overrun reporting and a valid/ready output.
// Build macro UART_RX_MAJORITY_EN: 2-of-3 majority over os=7,8,9, decided at os=9.
module uart_rx_gen2
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              Rx_EN,
    input  logic              Rx_D,
    input  logic              Rx_READY,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR,
    output logic              Rx_OVERRUN
);

    logic              rx_meta_q, rx_sync_q;
    logic              tick;
    logic              bit_val;
    rx_state_e         state_q;
    logic [3:0]        os_q;
    logic [3:0]        bit_cnt_q;
    logic              stop_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_acc_q, perr_q, ferr_q;
    logic              par_en_q, par_odd_q, stop2_q;
    logic [2:0]        baud_sel_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, perror_q, ferror_q, overrun_q;
    logic              decide, start_chk, bit_end, last_stop;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] StartOs  = 4'd9;
    localparam logic [3:0] DecideOs = 4'd9;

    logic [1:0] smp_q;

    // Keep the os=7 and os=8 samples for the vote taken at os=9.
    always_ff @(posedge clk) begin
        if (!reset) begin
            smp_q <= 2'b11;
        end else if (tick && (os_q == 4'd7 || os_q == 4'd8)) begin
            smp_q <= {smp_q[0], rx_sync_q};
        end
    end

    assign bit_val = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_sync_q) | (smp_q[0] & rx_sync_q);
`else
    localparam logic [3:0] StartOs  = 4'd7;
    localparam logic [3:0] DecideOs = 4'd8;

    assign bit_val = rx_sync_q;
`endif

    // Two-flop synchroniser; idle-high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx_D;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_baud_tick (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_sel_q),
        .tick        (tick)
    );

    // Tick-qualified decision points within the 16-tick bit window.
    always_comb begin
        start_chk = tick && (os_q == StartOs);
        decide    = tick && (os_q == DecideOs);
        bit_end   = tick && (os_q == 4'd15);
        last_stop = stop_cnt_q || !stop2_q;
    end

    // Receiver FSM, datapath and registered output handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StOff;
            os_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            baud_sel_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perror_q   <= 1'b0;
            ferror_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (!Rx_EN) begin
            // Abort any frame; the held word survives, status does not.
            state_q    <= StOff;
            os_q       <= '0;
            valid_q    <= 1'b0;
            perror_q   <= 1'b0;
            ferror_q   <= 1'b0;
            overrun_q  <= 1'b0;
            baud_sel_q <= baud_select;
            par_en_q   <= (parity_mode == ParEven) || (parity_mode == ParOdd);
            par_odd_q  <= (parity_mode == ParOdd);
            stop2_q    <= stop2;
        end else begin
            if (valid_q && Rx_READY) begin
                valid_q <= 1'b0;
            end
            if (tick) begin
                os_q <= os_q + 4'd1;
            end
            unique case (state_q)
                StOff, StIdle: begin
                    // Controls track the inputs here and freeze once a frame starts.
                    baud_sel_q <= baud_select;
                    par_en_q   <= (parity_mode == ParEven) || (parity_mode == ParOdd);
                    par_odd_q  <= (parity_mode == ParOdd);
                    stop2_q    <= stop2;
                    os_q       <= '0;
                    if (state_q == StOff) begin
                        state_q <= StIdle;
                    end else if (!rx_sync_q) begin
                        state_q    <= StStart;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        par_acc_q  <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                StStart: begin
                    // Confirmed mid start bit; data windows begin at the start-bit boundary.
                    if (start_chk && bit_val) begin
                        state_q <= StIdle;
                    end else if (bit_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_q   <= {bit_val, shift_q[DATA_W-1:1]};
                        par_acc_q <= par_acc_q ^ bit_val;
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == 4'(DATA_W - 1)) begin
                            state_q <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        perr_q <= par_acc_q ^ bit_val ^ par_odd_q;
                    end
                    if (bit_end) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (decide) begin
                        if (!bit_val) begin
                            ferr_q <= 1'b1;
                        end
                        if (!last_stop) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            if (!valid_q || Rx_READY) begin
                                data_q   <= shift_q;
                                valid_q  <= 1'b1;
                                perror_q <= perr_q;
                                ferror_q <= ferr_q | !bit_val;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign Rx_DATA    = data_q;
    assign Rx_VALID   = valid_q;
    assign Rx_PERROR  = perror_q;
    assign Rx_FERROR  = ferror_q;
    assign Rx_OVERRUN = overrun_q;

endmodule
